ctrl_pipe_chain: RTL and testbench
==================================

Name: ctrl_pipe_chain

Overview:
- Parametrised replacement for the fixed ID/EX, EX/MEM and MEM/WB control-signal registers.
- Carries a packed control word (RegWrite, MemWrite, MemtoReg, ALUSrc, ALUControl, …) through STAGES registered stages.
- Adds per-stage stall, flush and automatic bubble insertion, none of which the current fixed registers support.
- Sits between the cu_mux output and the datapath stage consumers.

Parameters:
STAGES, 3, number of pipeline stages after decode (min 1, max 8)
CTRL_W, 8, width of one packed control word
NOP_CTRL, 0, control word loaded on reset, flush or bubble
CNT_W, 16, width of performance counters (used only with the optional feature)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset
ctrl_in  input  CTRL_W  control word from cu_mux
valid_in  input  1  ctrl_in carries a real instruction
stall  input  STAGES  stall[i] freezes stage i and all earlier stages
flush  input  STAGES  flush[i] turns stage i into a bubble at the next edge
in_ready  output  1  upstream (IF/ID) may advance; low while stage 0 is held
stage_ctrl  output  STAGES*CTRL_W  stage i word at bits [i*CTRL_W +: CTRL_W]; stage STAGES-1 = WB
stage_valid  output  STAGES  per-stage valid
stall_cycles  output  CNT_W  cycles with in_ready=0 (optional feature)
bubble_count  output  CNT_W  bubbles inserted by stalls (optional feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - stage_valid=0 and every stage_ctrl slice = NOP_CTRL immediately.
  - Counters = 0.
  - in_ready = 1 while reset is asserted (no stall can be active in the combinational path).
  - Reset asserted mid-stream discards all in-flight words; no partial update.
- Hold term: hold[i] = OR of stall[j] for j = i..STAGES-1.
- in_ready = ~hold[0], combinational.
- Per-stage update at each rising edge, in priority order:
  1. flush[i]=1 → bubble (valid 0, ctrl NOP_CTRL). Wins over stall and over upstream data.
  2. hold[i]=1 → keep current contents.
  3. i>0 and hold[i-1]=1 → bubble (upstream frozen, so stage i drains).
  4. Otherwise load from upstream: stage i-1 contents, or for stage 0 {valid_in, ctrl_in}. valid_in=0 loads NOP_CTRL regardless of ctrl_in.
- A flushed stage that is also held becomes a bubble and stays a bubble while held. Upstream stages remain frozen.
- Latency: ctrl_in sampled at edge N appears in stage k after edge N+k (k = 0..STAGES-1) when nothing is stalled.
- stall[STAGES-1]=1 freezes the whole chain; no bubble is produced.
- Bubble-only stages (valid 0) must hold exactly NOP_CTRL. Downstream consumers rely on ctrl=0 meaning no write.
- stall/flush are sampled synchronously. No combinational path from stall/flush to stage_ctrl/stage_valid.

Optional Feature:
- Macro: CTRL_PIPE_PERF_CNT_EN.
- Defined:
  - stall_cycles increments each edge where in_ready=0.
  - bubble_count increments each edge where any stage takes rule 3 with the upstream stage valid (one increment per edge).
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports are driven constant 0 and no counter flops are synthesised. The port list is unchanged.

Decomposition:
- Shared package ctrl_pipe_pkg holds:
  - Control-word bit-index constants (REGWRITE_BIT, MEMWRITE_BIT, MEMTOREG_BIT, ALUSRC_BIT, ALUCTRL_LSB/MSB).
  - Default NOP constant.
  - STAGES maximum.
- One sub-module, ctrl_pipe_stage: a single {valid, ctrl} register with flush/hold/bubble/load priority.
- ctrl_pipe_chain instantiates STAGES copies via generate and adds the hold OR-chain and the optional counters.

Test Plan (STAGES=3, CTRL_W=8, NOP_CTRL=0x00 unless stated):
- Streaming: valid_in=1 with ctrl_in 0x11, 0x22, 0x33 on consecutive edges → stage2 shows 0x11, 0x22, 0x33 on the 3rd, 4th and 5th edges; all valid=1; in_ready stays 1.
- Stall with bubble: stages hold {0x33, 0x22, 0x11}; stall=3'b010 for 2 edges → stages 0/1 keep 0x33/0x22, stage2 becomes valid 0 / 0x00, in_ready=0. Release → 0x22 reaches stage2 on the next edge.
- Flush beats stall: stall=3'b010 with flush=3'b011 on one edge → stages 0 and 1 become bubbles (0x00, valid 0), stage2 becomes a bubble, in_ready=0.
- Async reset mid-stream: drop reset between edges with valid data in all stages → stage_valid=0 and ctrl=0x00 immediately without a clock edge; the first edge after release loads ctrl_in.
- Boundary STAGES=1: stall=1 holds a 0xA5 word indefinitely; flush=1 with stall=1 gives a bubble; valid_in=0 with ctrl_in=0xFF loads 0x00.
- Perf counters (CTRL_PIPE_PERF_CNT_EN, CNT_W=4): 20 consecutive stall[0] cycles → stall_cycles saturates at 15. Without the macro, both counters read 0.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ctrl_pipe_pkg : control-word field positions and chain-wide constants      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package ctrl_pipe_pkg;

   localparam int REGWRITE_BIT = 0;
   localparam int MEMWRITE_BIT = 1;
   localparam int MEMTOREG_BIT = 2;
   localparam int ALUSRC_BIT   = 3;
   localparam int ALUCTRL_LSB  = 4;
   localparam int ALUCTRL_MSB  = 7;

   // All-zero word means no register or memory write downstream.
   localparam logic [7:0] CTRL_NOP = 8'h00;

   localparam int STAGES_MAX = 8;

endpackage
`default_nettype wire

// File: rtl/ctrl_pipe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ctrl_pipe_stage : one {valid, ctrl} register, flush > hold > drain > load  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module ctrl_pipe_stage
   import ctrl_pipe_pkg::*;
#(
   parameter int                CTRL_W   = 8,
   parameter logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(CTRL_NOP)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              hold,
   input  logic              drain,
   input  logic              up_valid,
   input  logic [CTRL_W-1:0] up_ctrl,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         ctrl  <= NOP_CTRL;
      end else if (flush) begin
         valid <= 1'b0;
         ctrl  <= NOP_CTRL;
      end else if (!hold) begin
         if (drain) begin
            valid <= 1'b0;
            ctrl  <= NOP_CTRL;
         end else begin
            // Invalid upstream words are normalised so bubbles always carry NOP.
            valid <= up_valid;
            ctrl  <= up_valid ? up_ctrl : NOP_CTRL;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe_chain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ctrl_pipe_chain : STAGES-deep control-word pipe with stall/flush/bubbles;  |
// | CTRL_PIPE_PERF_CNT_EN adds stall-cycle and bubble counters.  Revision 1.0  |
// +----------------------------------------------------------------------------+
module ctrl_pipe_chain
   import ctrl_pipe_pkg::*;
#(
   parameter int                STAGES   = 3,
   parameter int                CTRL_W   = 8,
   parameter logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(CTRL_NOP),
   parameter int                CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [CTRL_W-1:0]        ctrl_in,
   input  logic                     valid_in,
   input  logic [STAGES-1:0]        stall,
   input  logic [STAGES-1:0]        flush,
   output logic                     in_ready,
   output logic [STAGES*CTRL_W-1:0] stage_ctrl,
   output logic [STAGES-1:0]        stage_valid,
   output logic [CNT_W-1:0]         stall_cycles,
   output logic [CNT_W-1:0]         bubble_count
);

   if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
      $error("ctrl_pipe_chain: STAGES out of range");
   end

   logic [STAGES-1:0] hold;
   logic [STAGES-1:0] bubble_evt;

   // A stall anywhere downstream freezes every earlier stage.
   always_comb begin
      logic acc;
      acc  = 1'b0;
      hold = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         acc     = acc | stall[i];
         hold[i] = acc;
      end
   end

   assign in_ready = ~hold[0] | ~reset;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic              up_valid;
      logic [CTRL_W-1:0] up_ctrl;
      logic              drain;

      if (i == 0) begin : g_head
         assign up_valid = valid_in;
         assign up_ctrl  = ctrl_in;
         assign drain    = 1'b0;
      end else begin : g_body
         assign up_valid = stage_valid[i-1];
         assign up_ctrl  = stage_ctrl[(i-1)*CTRL_W +: CTRL_W];
         assign drain    = hold[i-1];
      end

      assign bubble_evt[i] = drain & ~hold[i] & ~flush[i] & up_valid;

      ctrl_pipe_stage #(
         .CTRL_W   (CTRL_W),
         .NOP_CTRL (NOP_CTRL)
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .flush    (flush[i]),
         .hold     (hold[i]),
         .drain    (drain),
         .up_valid (up_valid),
         .up_ctrl  (up_ctrl),
         .valid    (stage_valid[i]),
         .ctrl     (stage_ctrl[i*CTRL_W +: CTRL_W])
      );
   end

`ifdef CTRL_PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] bubble_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (hold[0] && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (|bubble_evt && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

   assign stall_cycles = stall_cnt;
   assign bubble_count = bubble_cnt;
`else
   logic unused_evt;
   assign unused_evt   = ^bubble_evt;
   assign stall_cycles = '0;
   assign bubble_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_chain.sv
`default_nettype none
// Bench for ctrl_pipe_chain: directed scenarios then random traffic against a
// rule-level model, on a 3-stage (CNT_W=4) and a 1-stage instance.
module tb_ctrl_pipe_chain;

   localparam int S  = 3;
   localparam int W  = 8;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 3-stage DUT
   logic [W-1:0]   ctrl_in;
   logic           valid_in;
   logic [S-1:0]   stall, flush;
   logic           in_ready;
   logic [S*W-1:0] stage_ctrl;
   logic [S-1:0]   stage_valid;
   logic [CW-1:0]  stall_cycles, bubble_count;

   // 1-stage DUT
   logic [W-1:0]   a_ctrl_in;
   logic           a_valid_in;
   logic [0:0]     a_stall, a_flush;
   logic           a_in_ready;
   logic [W-1:0]   a_stage_ctrl;
   logic [0:0]     a_stage_valid;
   logic [15:0]    a_stall_cycles, a_bubble_count;

   ctrl_pipe_chain #(.STAGES(S), .CTRL_W(W), .NOP_CTRL(8'h00), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in),
      .stall(stall), .flush(flush), .in_ready(in_ready),
      .stage_ctrl(stage_ctrl), .stage_valid(stage_valid),
      .stall_cycles(stall_cycles), .bubble_count(bubble_count));

   ctrl_pipe_chain #(.STAGES(1), .CTRL_W(W), .NOP_CTRL(8'h00), .CNT_W(16)) dut1 (
      .clk(clk), .reset(reset), .ctrl_in(a_ctrl_in), .valid_in(a_valid_in),
      .stall(a_stall), .flush(a_flush), .in_ready(a_in_ready),
      .stage_ctrl(a_stage_ctrl), .stage_valid(a_stage_valid),
      .stall_cycles(a_stall_cycles), .bubble_count(a_bubble_count));

   int n_pass = 0;
   int n_total = 0;

   // Reference model state
   logic [W-1:0] m_ctrl [S];
   logic         m_valid[S];
   int           m_sc, m_bc;
   logic [W-1:0] am_ctrl;
   logic         am_valid;
   int           am_sc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic int cnt_exp(input int v);
`ifdef CTRL_PIPE_PERF_CNT_EN
      return v;
`else
      return 0;
`endif
   endfunction

   // Stage i is frozen when any stage from i onward is stalled.
   function automatic bit held(input int i);
      for (int j = i; j < S; j++)
         if (stall[j]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < S; i++) begin
         m_ctrl[i]  = '0;
         m_valid[i] = 1'b0;
      end
      m_sc = 0; m_bc = 0;
      am_ctrl = '0; am_valid = 1'b0; am_sc = 0;
   endtask

   task automatic model_edge();
      logic [W-1:0] nc[S];
      logic         nv[S];
      bit           bub;
      bub = 1'b0;
      for (int i = 0; i < S; i++) begin
         if (flush[i]) begin
            nv[i] = 1'b0; nc[i] = '0;
         end else if (held(i)) begin
            nv[i] = m_valid[i]; nc[i] = m_ctrl[i];
         end else if (i > 0 && held(i-1)) begin
            nv[i] = 1'b0; nc[i] = '0;
            if (m_valid[i-1]) bub = 1'b1;
         end else if (i == 0) begin
            nv[i] = valid_in; nc[i] = valid_in ? ctrl_in : '0;
         end else begin
            nv[i] = m_valid[i-1]; nc[i] = m_ctrl[i-1];
         end
      end
      if (held(0) && m_sc < 15) m_sc++;
      if (bub && m_bc < 15) m_bc++;
      m_valid = nv;
      m_ctrl  = nc;
      if (a_flush[0]) begin
         am_valid = 1'b0; am_ctrl = '0;
      end else if (!a_stall[0]) begin
         am_valid = a_valid_in; am_ctrl = a_valid_in ? a_ctrl_in : '0;
      end
      if (a_stall[0] && am_sc < 65535) am_sc++;
   endtask

   task automatic check_state(input string tag);
      chk($sformatf("%s.ctrl", tag), stage_ctrl, {m_ctrl[2], m_ctrl[1], m_ctrl[0]});
      chk($sformatf("%s.valid", tag), stage_valid, {m_valid[2], m_valid[1], m_valid[0]});
      chk($sformatf("%s.stall_cycles", tag), stall_cycles, cnt_exp(m_sc));
      chk($sformatf("%s.bubble_count", tag), bubble_count, cnt_exp(m_bc));
      chk($sformatf("%s.s1ctrl", tag), a_stage_ctrl, am_ctrl);
      chk($sformatf("%s.s1valid", tag), a_stage_valid, am_valid);
      chk($sformatf("%s.s1cnt", tag), {a_bubble_count, a_stall_cycles}, {16'h0, 16'(cnt_exp(am_sc))});
   endtask

   // Inputs are already driven; check the combinational ready, clock, then compare.
   task automatic step(input string tag);
      #1;
      chk($sformatf("%s.in_ready", tag), in_ready, !held(0));
      chk($sformatf("%s.s1in_ready", tag), a_in_ready, !a_stall[0]);
      @(posedge clk);
      model_edge();
      #1;
      check_state(tag);
   endtask

   initial begin
      reset = 1'b0;
      ctrl_in = '0; valid_in = 1'b0; stall = 3'b111; flush = '0;
      a_ctrl_in = '0; a_valid_in = 1'b0; a_stall = 1'b1; a_flush = 1'b0;
      model_reset();
      #1;
      check_state("reset");
      chk("reset.in_ready", in_ready, 1'b1);
      stall = '0; a_stall = 1'b0;
      #1 reset = 1'b1;

      // Streaming
      valid_in = 1'b1;
      ctrl_in = 8'h11; step("stream1");
      ctrl_in = 8'h22; step("stream2");
      ctrl_in = 8'h33; step("stream3");
      chk("stream.stage2_first", stage_ctrl[23:16], 8'h11);
      ctrl_in = 8'h44; valid_in = 1'b0;
      // Hold {0x33,0x22,0x11}: stall stage 1 and upstream stays frozen.
      stall = 3'b010; valid_in = 1'b1; ctrl_in = 8'h44;
      #1 chk("stall.in_ready_low", in_ready, 1'b0);
      step("stall1");
      step("stall2");
      chk("stall.stage2_bubble", {stage_valid[2], stage_ctrl[23:16]}, 9'h000);
      chk("stall.stage01_kept", stage_ctrl[15:0], 16'h2233);
      stall = '0;
      step("release");
      chk("release.stage2", stage_ctrl[23:16], 8'h22);

      // Flush wins over stall
      step("refill");
      stall = 3'b010; flush = 3'b011;
      step("flush_stall");
      chk("flush_stall.all_bubble", {stage_valid, stage_ctrl}, 27'h0);
      stall = '0; flush = '0;
      step("flush_release");
      step("fill_a");
      step("fill_b");

      // Asynchronous reset between edges
      reset = 1'b0; stall = 3'b111; a_stall = 1'b1;
      model_reset();
      #1;
      check_state("async_reset");
      chk("async_reset.in_ready", in_ready, 1'b1);
      reset = 1'b1; stall = '0; a_stall = 1'b0;
      ctrl_in = 8'h5A; valid_in = 1'b1;
      step("post_reset");
      chk("post_reset.stage0", {stage_valid[0], stage_ctrl[7:0]}, 9'h15A);

      // Single-stage boundary
      a_ctrl_in = 8'hA5; a_valid_in = 1'b1;
      step("s1_load");
      a_stall = 1'b1; a_ctrl_in = 8'h3C;
      for (int k = 0; k < 4; k++) step("s1_hold");
      chk("s1_hold.A5", {a_stage_valid, a_stage_ctrl}, 9'h1A5);
      a_flush = 1'b1;
      step("s1_flush_stall");
      chk("s1_flush_stall.bubble", {a_stage_valid, a_stage_ctrl}, 9'h000);
      a_flush = 1'b0; a_stall = 1'b0; a_valid_in = 1'b0; a_ctrl_in = 8'hFF;
      step("s1_invalid");
      chk("s1_invalid.nop", {a_stage_valid, a_stage_ctrl}, 9'h000);

      // Counter saturation on a long stage-0 stall
      stall = 3'b001;
      for (int k = 0; k < 20; k++) step("sat");
      chk("sat.stall_cycles", stall_cycles, cnt_exp(15));
      stall = '0;
      step("sat_release");

      reset = 1'b0;
      model_reset();
      #1 reset = 1'b1;

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < S; i++) begin
            stall[i] = ($urandom_range(0, 5) == 0);
            flush[i] = ($urandom_range(0, 9) == 0);
         end
         valid_in   = $urandom_range(0, 3) != 0;
         ctrl_in    = W'($urandom);
         a_stall    = ($urandom_range(0, 3) == 0);
         a_flush    = ($urandom_range(0, 7) == 0);
         a_valid_in = $urandom_range(0, 1) != 0;
         a_ctrl_in  = W'($urandom);
         step($sformatf("rand%0d", k));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
